// File: rtl/mpsq_udiv_29ns_16ns_14_seq_if.sv
// mpsq_udiv_29ns_16ns_14_seq_if: operand/result handshake bundle for the sequential 29/16 divider.
interface mpsq_udiv_29ns_16ns_14_seq_if;
    logic [28:0] din0;
    logic [15:0] din1;
    logic        din_vld;
    logic        din_rdy;
    logic [13:0] dout;
    logic [15:0] rem;
    logic        ovf;
    logic        dz;
    logic        dout_vld;
    logic        dout_rdy;

    modport master (
        output din0, din1, din_vld, dout_rdy,
        input  din_rdy, dout, rem, ovf, dz, dout_vld
    );

    modport slave (
        input  din0, din1, din_vld, dout_rdy,
        output din_rdy, dout, rem, ovf, dz, dout_vld
    );
endinterface

// File: rtl/mpsq_udiv_29ns_16ns_14_seq.sv
// mpsq_udiv_29ns_16ns_14_seq: radix-2 restoring unsigned divider, 29-bit dividend by 16-bit divisor,
// 14-bit saturating quotient with overflow and divide-by-zero flags, one bit per enabled clock.
module mpsq_udiv_29ns_16ns_14_seq #(
    parameter ID         = 32'd1,
    parameter din0_WIDTH = 29,
    parameter din1_WIDTH = 16,
    parameter dout_WIDTH = 14
) (
    input logic                          clk,
    input logic                          reset,
    input logic                          ce,
    mpsq_udiv_29ns_16ns_14_seq_if.slave  bus
);
    if (din0_WIDTH != 29 || din1_WIDTH != 16 || dout_WIDTH != 14)
        $error("mpsq_udiv_29ns_16ns_14_seq supports only the 29/16/14 configuration");

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state;
    logic [4:0]              cnt;
    logic [din0_WIDTH-1:0]   dividend;
    logic [din1_WIDTH-1:0]   divisor;
    logic [din1_WIDTH-1:0]   prem;
    logic [din0_WIDTH-1:0]   quot;
    logic [dout_WIDTH-1:0]   dout_q;
    logic [din1_WIDTH-1:0]   rem_q;
    logic                    ovf_q;
    logic                    dz_q;

    logic [din1_WIDTH:0]     r_sh;
    logic                    ge;
    logic [din1_WIDTH-1:0]   prem_n;
    logic [din0_WIDTH-1:0]   quot_n;
    logic                    q_ovf;

    // The partial remainder stays below the divisor, so only the shifted value needs the 17th bit.
    always_comb begin
        r_sh   = {prem, dividend[din0_WIDTH-1]};
        ge     = r_sh >= {1'b0, divisor};
        prem_n = ge ? 16'(r_sh - {1'b0, divisor}) : r_sh[din1_WIDTH-1:0];
        quot_n = {quot[din0_WIDTH-2:0], ge};
        q_ovf  = |quot_n[din0_WIDTH-1:dout_WIDTH];
    end

    assign bus.din_rdy  = reset && state == IDLE;
    assign bus.dout_vld = state == DONE;
    assign bus.dout     = dout_q;
    assign bus.rem      = rem_q;
    assign bus.ovf      = ovf_q;
    assign bus.dz       = dz_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= '0;
            dividend <= '0;
            divisor  <= '0;
            prem     <= '0;
            quot     <= '0;
            dout_q   <= '0;
            rem_q    <= '0;
            ovf_q    <= 1'b0;
            dz_q     <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: if (bus.din_vld) begin
                    dividend <= bus.din0;
                    divisor  <= bus.din1;
                    prem     <= '0;
                    quot     <= '0;
                    cnt      <= '0;
                    if (bus.din1 == '0) begin
                        state  <= DONE;
                        dz_q   <= 1'b1;
                        ovf_q  <= 1'b0;
                        dout_q <= '1;
                        rem_q  <= '0;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    dividend <= dividend << 1;
                    prem     <= prem_n;
                    quot     <= quot_n;
                    cnt      <= cnt + 5'd1;
                    if (cnt == 5'd28) begin
                        state  <= DONE;
                        ovf_q  <= q_ovf;
                        dout_q <= q_ovf ? '1 : quot_n[dout_WIDTH-1:0];
                        rem_q  <= prem_n;
                        dz_q   <= 1'b0;
                    end
                end
                DONE: if (bus.dout_rdy) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mpsq_udiv_29ns_16ns_14_seq.sv
// tb_mpsq_udiv_29ns_16ns_14_seq: directed vector table plus hand-written ce-stall, result-hold
// and mid-calculation reset sequences for the sequential divider.
module tb_mpsq_udiv_29ns_16ns_14_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b1;
    int   tests = 0;
    int   failed = 0;

    mpsq_udiv_29ns_16ns_14_seq_if bus ();

    mpsq_udiv_29ns_16ns_14_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [28:0] a;
        logic [15:0] b;
        logic [13:0] q;
        logic [15:0] r;
        logic        o;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Starts and ends on a falling edge; ce is dropped for off_len edges starting after edge off_at.
    task automatic op(input logic [28:0] a, input logic [15:0] b, input int off_at, input int off_len,
                      output int lat);
        int g = 0;
        while (!bus.din_rdy && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("din_rdy_before_accept", 32'(bus.din_rdy), 32'd1);
        bus.din0 = a;
        bus.din1 = b;
        bus.din_vld = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.din_vld = 1'b0;
        bus.din0 = 29'($urandom);
        bus.din1 = 16'($urandom);
        while (!bus.dout_vld && lat < 100) begin
            ce = !(lat >= off_at && lat < off_at + off_len);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ce = 1'b1;
    endtask

    task automatic consume();
        bus.dout_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.dout_rdy = 1'b0;
        chk("dout_vld_after_consume", 32'(bus.dout_vld), 32'd0);
        chk("din_rdy_after_consume", 32'(bus.din_rdy), 32'd1);
    endtask

    initial begin
        int lat;
        vecs[0] = '{29'd300007,    16'd300,   14'd1000,  16'd7,    1'b0, 1'b0, 30};
        vecs[1] = '{29'd536870911, 16'd65535, 14'd8192,  16'd8191, 1'b0, 1'b0, 30};
        vecs[2] = '{29'd536870911, 16'd1,     14'd16383, 16'd0,    1'b1, 1'b0, 30};
        vecs[3] = '{29'd12345,     16'd0,     14'd16383, 16'd0,    1'b0, 1'b1, 1};
        vecs[4] = '{29'd1000,      16'd3,     14'd333,   16'd1,    1'b0, 1'b0, 30};
        vecs[5] = '{29'd81922,     16'd5,     14'd16383, 16'd2,    1'b1, 1'b0, 30};
        vecs[6] = '{29'd81919,     16'd5,     14'd16383, 16'd4,    1'b0, 1'b0, 30};
        bus.din0 = '0;
        bus.din1 = '0;
        bus.din_vld = 1'b0;
        bus.dout_rdy = 1'b0;
        #1;
        chk("rst_din_rdy", 32'(bus.din_rdy), 32'd0);
        chk("rst_dout_vld", 32'(bus.dout_vld), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_rem", 32'(bus.rem), 32'd0);
        chk("rst_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("din_rdy_after_release", 32'(bus.din_rdy), 32'd1);

        for (int i = 0; i < 7; i++) begin
            op(vecs[i].a, vecs[i].b, 0, 0, lat);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_dout", i), 32'(bus.dout), 32'(vecs[i].q));
            chk($sformatf("v%0d_rem", i), 32'(bus.rem), 32'(vecs[i].r));
            chk($sformatf("v%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].o));
            chk($sformatf("v%0d_dz", i), 32'(bus.dz), 32'(vecs[i].z));
            consume();
        end

        op(29'd300000, 16'd300, 10, 5, lat);
        chk("stall_latency", 32'(lat), 32'd35);
        chk("stall_dout", 32'(bus.dout), 32'd1000);
        chk("stall_rem", 32'(bus.rem), 32'd0);
        bus.din0 = 29'd7;
        bus.din1 = 16'd1;
        bus.din_vld = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_dout_vld", 32'(bus.dout_vld), 32'd1);
            chk("hold_din_rdy", 32'(bus.din_rdy), 32'd0);
            chk("hold_dout", 32'(bus.dout), 32'd1000);
            chk("hold_rem_flags", {bus.rem, 14'd0, bus.ovf, bus.dz}, 32'd0);
        end
        bus.din_vld = 1'b0;
        consume();

        bus.din0 = 29'd300007;
        bus.din1 = 16'd300;
        bus.din_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.din_vld = 1'b0;
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("calc_din_rdy", 32'(bus.din_rdy), 32'd0);
        chk("calc_dout_retained", 32'(bus.dout), 32'd1000);
        #2 reset = 1'b0;
        #1;
        chk("midrst_dout", 32'(bus.dout), 32'd0);
        chk("midrst_rem", 32'(bus.rem), 32'd0);
        chk("midrst_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);
        chk("midrst_dout_vld", 32'(bus.dout_vld), 32'd0);
        chk("midrst_din_rdy", 32'(bus.din_rdy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_release_rdy", 32'(bus.din_rdy), 32'd1);
        op(29'd100, 16'd7, 0, 0, lat);
        chk("post_rst_latency", 32'(lat), 32'd30);
        chk("post_rst_dout", 32'(bus.dout), 32'd14);
        chk("post_rst_rem", 32'(bus.rem), 32'd2);
        chk("post_rst_flags", {30'd0, bus.ovf, bus.dz}, 32'd0);
        consume();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
